// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD complement sequencer.
//   BCD_W        : width of one BCD digit
//   bcd_digit_t  : one packed BCD digit
//   state_t      : sequencer FSM states
//   is_bcd_valid : true when a nibble holds a legal decimal digit (0-9)
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    function automatic logic is_bcd_valid(input bcd_digit_t digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_nines_digit.sv
// Combinational single-digit BCD 9's complementer.
//   digit : 4-bit input nibble (a,b,c,d = MSB..LSB)
//   nines : 9 - digit for legal digits; any nibble maps to a value <= 9
module bcd_nines_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] nines
);

    logic a, b, c, d;

    assign {a, b, c, d} = digit;

    // w = ~a&~b&~c, x = b^c, y = c, z = ~d
    assign nines = {~a & ~b & ~c, b ^ c, c, ~d};

endmodule

// File: rtl/bcd_complement_sequencer.sv
// Digit-serial BCD 9's / 10's complementer, least-significant digit first.
// One shared bcd_nines_digit instance is muxed across the operand digits.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request pulse, accepted only when idle
//   mode  : 0 = 9's complement, 1 = 10's complement (sampled with start)
//   din   : packed BCD operand, digit i = din[4i+3:4i] (sampled with start)
//   busy  : conversion in progress
//   done  : one-cycle pulse when dout/cout/err are valid
//   dout  : packed result, held until the next accepted start
//   cout  : final decimal carry (always 0 in 9's mode)
//   err   : some input nibble was greater than 9
module bcd_complement_sequencer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic [BCD_W*DIGITS-1:0] din,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] dout,
    output logic                    cout,
    output logic                    err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                  state_reg, state_next;
    logic [BCD_W*DIGITS-1:0] operand_reg;
    logic [BCD_W*DIGITS-1:0] dout_reg, dout_next;
    logic [IDX_W-1:0]        index_reg;
    logic                    carry_reg, carry_next;
    logic                    cout_reg;
    logic                    err_reg;

    bcd_digit_t              op_digits [DIGITS];
    bcd_digit_t              cur_digit;
    bcd_digit_t              nines_digit;
    bcd_digit_t              sum_digit;
    bcd_digit_t              res_digit;
    logic                    last_digit;

    // Split the operand into digits so the current one can be picked by index.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_split
        assign op_digits[gi] = operand_reg[gi*BCD_W +: BCD_W];
    end

    assign cur_digit  = op_digits[index_reg];
    assign last_digit = (index_reg == IDX_W'(DIGITS - 1));

    bcd_nines_digit u_nines (
        .digit (cur_digit),
        .nines (nines_digit)
    );

    // nines_digit <= 9, so the sum never exceeds 10 and a decimal carry
    // only arises from exactly 10.
    assign sum_digit  = nines_digit + {3'b000, carry_reg};
    assign carry_next = (sum_digit == 4'd10);
    assign res_digit  = carry_next ? 4'd0 : sum_digit;

    // Only the nibble at the current index is replaced; the rest keep
    // whatever they held (possibly from the previous conversion).
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_merge
        assign dout_next[gi*BCD_W +: BCD_W] =
            (index_reg == IDX_W'(gi)) ? res_digit : dout_reg[gi*BCD_W +: BCD_W];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = STEP;
            STEP:    if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            STEP:    busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_reg <= '0;
            dout_reg    <= '0;
            index_reg   <= '0;
            carry_reg   <= 1'b0;
            cout_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        operand_reg <= din;
                        // The 10's complement is the 9's complement plus an
                        // initial carry into digit 0.
                        carry_reg   <= mode;
                        index_reg   <= '0;
                        err_reg     <= 1'b0;
                        cout_reg    <= 1'b0;
                    end
                end
                STEP: begin
                    dout_reg  <= dout_next;
                    carry_reg <= carry_next;
                    err_reg   <= err_reg | ~is_bcd_valid(cur_digit);
                    if (last_digit) begin
                        cout_reg <= carry_next;
                    end else begin
                        index_reg <= index_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = dout_reg;
    assign cout = cout_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd_complement_sequencer.sv
// Self-checking bench for bcd_complement_sequencer (DIGITS = 4).
// Expected results come from a decimal-arithmetic reference model and are
// queued when a start is driven, then popped when done is seen.
module tb_bcd_complement_sequencer;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] dout;
        logic         cout;
        logic         err;
    } result_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [W-1:0] din;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         cout;
    logic         err;

    result_t      exp_q [$];
    int           checks   = 0;
    int           failures = 0;

    bcd_complement_sequencer #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: legal digit d -> 9-d, nibbles 10..15 -> 17-d
    // (the complementer's fixed response to illegal codes). 10's mode adds
    // one to the decimal value of the 9's result, overflow giving cout.
    function automatic result_t model(input logic [W-1:0] d, input logic m);
        result_t r;
        int      value = 0;
        int      scale = 1;
        int      nib;
        r.err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(d[i*4 +: 4]);
            if (nib > 9) begin
                r.err = 1'b1;
                value += (17 - nib) * scale;
            end else begin
                value += (9 - nib) * scale;
            end
            scale *= 10;
        end
        if (m) value += 1;
        r.cout = (value == scale);
        if (value == scale) value = 0;
        r.dout = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r.dout[i*4 +: 4] = 4'(value % 10);
            value /= 10;
        end
        return r;
    endfunction

    // Drive one request, then wait (bounded) for done and score it.
    task automatic run_conv(input string tag, input logic [W-1:0] d, input logic m);
        result_t exp;
        result_t got;
        int      cycles = 0;
        bit      seen   = 0;
        @(negedge clk);
        check_eq({tag, "_idle_done_low"}, {31'd0, done}, 32'd0);
        din   = d;
        mode  = m;
        start = 1'b1;
        exp_q.push_back(model(d, m));
        @(negedge clk);
        start = 1'b0;
        din   = ~d;
        mode  = ~m;
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cycles = 1;
        while (!seen && cycles < 20) begin
            if (done) begin
                seen = 1;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        if (!seen) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, "_latency"}, cycles, DIGITS + 1);
        exp = exp_q.pop_front();
        got.dout = dout;
        got.cout = cout;
        got.err  = err;
        check_eq({tag, "_dout"}, {16'd0, got.dout}, {16'd0, exp.dout});
        check_eq({tag, "_cout"}, {31'd0, got.cout}, {31'd0, exp.cout});
        check_eq({tag, "_err"},  {31'd0, got.err},  {31'd0, exp.err});
        $display("txn %s din=0x%04h mode=%0d dout=0x%04h cout=%0d err=%0d", tag, d, m, dout, cout, err);
    endtask

    initial begin
        int      busy_cnt;
        int      done_cnt;
        int      guard;
        result_t exp;
        logic [W-1:0] base;
        logic [W-1:0] d;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        din   = '0;
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_dout", {16'd0, dout}, 32'd0);
        check_eq("rst_cout", {31'd0, cout}, 32'd0);
        check_eq("rst_err",  {31'd0, err},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_conv("nines_1234", 16'h1234, 1'b0);
        run_conv("tens_1234",  16'h1234, 1'b1);
        run_conv("tens_0000",  16'h0000, 1'b1);
        run_conv("inv_12A4",   16'h12A4, 1'b0);
        // Result must hold after done until the next start.
        repeat (3) @(negedge clk);
        check_eq("hold_dout", {16'd0, dout}, 32'h8775);
        check_eq("hold_err",  {31'd0, err},  32'd1);
        check_eq("hold_busy", {31'd0, busy}, 32'd0);
        run_conv("nines_0009", 16'h0009, 1'b0);

        // Start held high the whole run; a mid-run din change must be ignored.
        @(negedge clk);
        din   = 16'h1234;
        mode  = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(16'h1234, 1'b0));
        @(negedge clk);
        din      = 16'h5555;
        mode     = 1'b1;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        guard    = 0;
        while (busy && guard < 20) begin
            if (done) begin
                done_cnt++;
                exp = exp_q.pop_front();
                check_eq("hs_dout", {16'd0, dout}, {16'd0, exp.dout});
                check_eq("hs_cout", {31'd0, cout}, {31'd0, exp.cout});
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
            if (busy) busy_cnt++;
        end
        check_eq("hs_done_count", done_cnt, 1);
        check_eq("hs_busy_cycles", busy_cnt, DIGITS + 1);
        check_eq("hs_queue_empty", exp_q.size(), 0);
        start = 1'b0;
        $display("txn handshake dout=0x%04h dones=%0d busy_cycles=%0d", dout, done_cnt, busy_cnt);

        // Asynchronous reset in the second STEP cycle, between edges.
        @(negedge clk);
        din   = 16'h1234;
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_dout", {16'd0, dout}, 32'd0);
        check_eq("arst_cout", {31'd0, cout}, 32'd0);
        check_eq("arst_err",  {31'd0, err},  32'd0);
        $display("txn async_reset busy=%0d dout=0x%04h", busy, dout);
        @(negedge clk);
        rst_n = 1'b1;
        run_conv("tens_0999", 16'h0999, 1'b1);
        check_eq("tens_0999_fixed", {16'd0, dout}, 32'h9001);

        // Every nibble value in every position, both modes.
        base = 16'h5078;
        for (int pos = 0; pos < DIGITS; pos++) begin
            for (int v = 0; v < 16; v++) begin
                for (int m = 0; m < 2; m++) begin
                    d = base;
                    d[pos*4 +: 4] = 4'(v);
                    run_conv($sformatf("sweep_p%0d_v%0d_m%0d", pos, v, m), d, 1'(m));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
